// File: rtl/shader_pkg.sv
// Shared constants for the shader dispatch queue: shader IDs, VP opcodes,
// 8.8 fixed-point constants and the dispatch FSM encoding.
package shader_pkg;

    localparam logic [3:0] SH_RED     = 4'd0;
    localparam logic [3:0] SH_GREEN   = 4'd1;
    localparam logic [3:0] SH_LENGTH  = 4'd2;
    localparam logic [3:0] SH_CHECKER = 4'd3;
    localparam logic [3:0] SH_ANIM    = 4'd4;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_SUB    = 4'd1,
        OP_SCALE  = 4'd4,
        OP_LENGTH = 4'd5
    } vp_op_t;

    localparam logic [15:0] FP_ONE  = 16'h0100;
    localparam logic [15:0] FP_HALF = 16'h0080;
    localparam logic [15:0] FP_FULL = 16'hFF00;

    localparam logic [23:0] ERR_COLOR = 24'hFF00FF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUTPUT
    } state_t;

    function automatic logic [7:0] inv_byte(input logic [7:0] b);
        return 8'hFF - b;
    endfunction

endpackage

// File: rtl/shader_req_fifo.sv
// Synchronous request FIFO. A push while full is dropped even if a pop
// happens in the same cycle; pix_ready upstream is derived from full.
module shader_req_fifo #(
    parameter int WIDTH      = 24,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   level
);

    localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/shader_dispatch_queue.sv
// Queues pixel shading requests, issues one vector-processor op per pixel and
// returns colours in request order, with a WAIT timeout producing an error colour.
module shader_dispatch_queue
    import shader_pkg::*;
#(
    parameter int DATA_WIDTH      = 16,
    parameter int VECTOR_WIDTH    = 4,
    parameter int FIFO_DEPTH      = 8,
    parameter int FIFO_ADDR_WIDTH = 3,
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int CHECK_SHIFT     = 5,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               pix_valid,
    output logic                               pix_ready,
    input  logic [9:0]                         pix_x,
    input  logic [9:0]                         pix_y,
    input  logic [3:0]                         pix_shader,
    input  logic                               frame_start,
    output logic                               color_valid,
    input  logic                               color_ready,
    output logic [7:0]                         color_r,
    output logic [7:0]                         color_g,
    output logic [7:0]                         color_b,
    output logic                               color_err,
    output logic [FIFO_ADDR_WIDTH:0]           fifo_level,
    output logic                               vp_start,
    output logic [3:0]                         vp_operation,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0] vp_vec_a,
    output logic [VECTOR_WIDTH*DATA_WIDTH-1:0] vp_vec_b,
    output logic [DATA_WIDTH-1:0]              vp_scalar,
    input  logic                               vp_busy,
    input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] vp_result,
    input  logic                               vp_result_valid
);

    // Both streams transfer on a cycle where valid && ready; a producer holds
    // valid and its payload unchanged until that cycle, ready may toggle freely.

    localparam int VEC_W   = VECTOR_WIDTH*DATA_WIDTH;
    localparam int ENTRY_W = 24;
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES-1);

    localparam logic [DATA_WIDTH-1:0] C_ZERO = '0;
    localparam logic [DATA_WIDTH-1:0] C_FULL = DATA_WIDTH'(FP_FULL);
    localparam logic [DATA_WIDTH-1:0] C_ONE  = DATA_WIDTH'(FP_ONE);
    localparam logic [DATA_WIDTH-1:0] C_HALF = DATA_WIDTH'(FP_HALF);
    localparam logic [DATA_WIDTH-1:0] C_8000 = DATA_WIDTH'(16'h8000);
    localparam logic [DATA_WIDTH-1:0] C_4000 = DATA_WIDTH'(16'h4000);
    localparam logic [DATA_WIDTH-1:0] C_C000 = DATA_WIDTH'(16'hC000);

    state_t               state;
    logic [9:0]           cur_x;
    logic [9:0]           cur_y;
    logic [3:0]           cur_shader;
    logic [7:0]           anim;
    logic [TMO_W-1:0]     tmo_cnt;

    logic [ENTRY_W-1:0]   fifo_rd_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;

    assign pix_ready = !fifo_full;
    assign fifo_pop  = (state == ST_IDLE) && !fifo_empty && !vp_busy;

    shader_req_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (pix_valid),
        .wr_data ({pix_x, pix_y, pix_shader}),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    logic [17:0]           num_x;
    logic [17:0]           num_y;
    logic [DATA_WIDTH-1:0] norm_x;
    logic [DATA_WIDTH-1:0] norm_y;
    logic [DATA_WIDTH-1:0] cent_x;
    logic [DATA_WIDTH-1:0] cent_y;
    logic [DATA_WIDTH-1:0] anim_s;
    logic                  checker_on;

    assign num_x      = {cur_x, 8'd0};
    assign num_y      = {cur_y, 8'd0};
    assign norm_x     = DATA_WIDTH'(num_x / 18'(SCREEN_W));
    assign norm_y     = DATA_WIDTH'(num_y / 18'(SCREEN_H));
    assign cent_x     = norm_x - C_HALF;
    assign cent_y     = norm_y - C_HALF;
    assign anim_s     = DATA_WIDTH'(norm_x[7:0] + anim);
    assign checker_on = cur_x[CHECK_SHIFT] ^ cur_y[CHECK_SHIFT];

    vp_op_t                nxt_op;
    logic [DATA_WIDTH-1:0] nxt_scalar;
    logic [DATA_WIDTH-1:0] l3, l2, l1, l0;

    // Lane 3 is the most significant lane of the packed operand.
    always_comb begin
        nxt_op     = OP_SCALE;
        nxt_scalar = C_ONE;
        l3 = C_8000;
        l2 = C_4000;
        l1 = C_C000;
        l0 = C_FULL;
        case (cur_shader)
            SH_RED: begin
                l3 = C_FULL; l2 = C_ZERO; l1 = C_ZERO; l0 = C_FULL;
                nxt_scalar = norm_x;
            end
            SH_GREEN: begin
                l3 = C_ZERO; l2 = C_FULL; l1 = C_ZERO; l0 = C_FULL;
                nxt_scalar = norm_y;
            end
            SH_LENGTH: begin
                nxt_op = OP_LENGTH;
                l3 = cent_x; l2 = cent_y; l1 = C_ZERO; l0 = C_ZERO;
                nxt_scalar = C_ZERO;
            end
            SH_CHECKER: begin
                l3 = C_FULL; l2 = C_FULL; l1 = C_FULL; l0 = C_FULL;
                nxt_scalar = checker_on ? C_ONE : C_ZERO;
            end
            SH_ANIM: begin
                l3 = anim_s; l2 = C_8000; l1 = anim_s; l0 = C_FULL;
            end
            default: ;
        endcase
    end

    logic [7:0] res_r;
    logic [7:0] res_g;
    logic [7:0] res_b;
    logic       unused_result_bits;

    assign res_r = vp_result[4*DATA_WIDTH-1 -: 8];
    assign res_g = vp_result[3*DATA_WIDTH-1 -: 8];
    assign res_b = vp_result[2*DATA_WIDTH-1 -: 8];
    assign unused_result_bits = ^vp_result;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            anim <= '0;
        end else if (frame_start) begin
            anim <= anim + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cur_x        <= '0;
            cur_y        <= '0;
            cur_shader   <= '0;
            tmo_cnt      <= '0;
            vp_start     <= 1'b0;
            vp_operation <= OP_NOP;
            vp_vec_a     <= '0;
            vp_vec_b     <= '0;
            vp_scalar    <= '0;
            color_valid  <= 1'b0;
            color_r      <= '0;
            color_g      <= '0;
            color_b      <= '0;
            color_err    <= 1'b0;
        end else begin
            vp_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        {cur_x, cur_y, cur_shader} <= fifo_rd_data;
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    vp_start     <= 1'b1;
                    vp_operation <= nxt_op;
                    vp_vec_a     <= VEC_W'({l3, l2, l1, l0});
                    vp_vec_b     <= '0;
                    vp_scalar    <= nxt_scalar;
                    tmo_cnt      <= '0;
                    state        <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (vp_result_valid) begin
                        color_valid <= 1'b1;
                        color_err   <= 1'b0;
                        color_r     <= res_r;
                        if (cur_shader == SH_LENGTH) begin
                            color_g <= res_r;
                            color_b <= inv_byte(res_r);
                        end else begin
                            color_g <= res_g;
                            color_b <= res_b;
                        end
                        state <= ST_OUTPUT;
                    end else if (tmo_cnt == TMO_LAST) begin
                        color_valid <= 1'b1;
                        color_err   <= 1'b1;
                        {color_r, color_g, color_b} <= ERR_COLOR;
                        state <= ST_OUTPUT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_OUTPUT: begin
                    if (color_ready) begin
                        color_valid <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
